// File: rtl/hack_fetch_unit.sv
// rtl/hack_fetch_unit.sv - Hack CPU instruction fetch: ROM requester with a 2-entry instruction buffer
// A redirect flushes the buffer; a request already in flight is drained and its data discarded.

module hack_fetch_unit (
  input  logic        clock,
  input  logic        reset,
  output logic        rom_req,
  output logic [14:0] rom_addr,
  input  logic        rom_ack,
  input  logic [15:0] rom_data,
  input  logic        jump,
  input  logic [14:0] jump_addr,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [15:0] inst_data,
  output logic [14:0] inst_pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [14:0] fetch_pc;
  logic [15:0] slot_data [2];
  logic [14:0] slot_pc   [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [1:0]  count_after_pop;
  logic        pop;
  logic        push;
  logic        load_addr;

  assign inst_valid      = (count != 2'd0);
  assign inst_data       = slot_data[rd_ptr];
  assign inst_pc         = slot_pc[rd_ptr];
  assign pop             = inst_valid && inst_ready && !jump;
  assign count_after_pop = count - {1'b0, pop};

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A jump in REQ without an ack must still wait out the outstanding ROM cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (jump || (count_after_pop < 2'd2)) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (rom_ack) begin
          state_next = IDLE;
        end else if (jump) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (rom_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    load_addr = 1'b0;
    case (state)
      IDLE:    load_addr = (state_next == REQ);
      REQ:     push      = rom_ack && !jump;
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rom_req      <= 1'b0;
      rom_addr     <= 15'd0;
      fetch_pc     <= 15'd0;
      count        <= 2'd0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      slot_data[0] <= 16'd0;
      slot_data[1] <= 16'd0;
      slot_pc[0]   <= 15'd0;
      slot_pc[1]   <= 15'd0;
    end else begin
      rom_req <= (state_next != IDLE);
      if (load_addr) begin
        rom_addr <= jump ? jump_addr : fetch_pc;
      end

      if (jump) begin
        fetch_pc <= jump_addr;
      end else if (push) begin
        fetch_pc <= rom_addr + 15'd1;
      end

      if (push) begin
        slot_data[wr_ptr] <= rom_data;
        slot_pc[wr_ptr]   <= rom_addr;
      end

      // Flush wins over any pop or push in the same cycle.
      if (jump) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_hack_fetch_unit.sv
// tb/tb_hack_fetch_unit.sv - scoreboard bench for hack_fetch_unit with a behavioural ROM
// ROM returns addr+0x1000; one selectable address answers after a 3-cycle wait.

module tb_hack_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        rom_req;
  logic [14:0] rom_addr;
  logic        rom_ack;
  logic [15:0] rom_data;
  logic        jump;
  logic [14:0] jump_addr;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst_data;
  logic [14:0] inst_pc;

  logic        auto_ack = 1'b0;
  logic        man_ack;
  logic [14:0] slow_addr;
  int          wait_cnt = 0;
  int          checks = 0;
  int          fails = 0;

  typedef struct packed {
    logic [14:0] pc;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];

  hack_fetch_unit dut (
    .clock      (clock),
    .reset      (reset),
    .rom_req    (rom_req),
    .rom_addr   (rom_addr),
    .rom_ack    (rom_ack),
    .rom_data   (rom_data),
    .jump       (jump),
    .jump_addr  (jump_addr),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_data  (inst_data),
    .inst_pc    (inst_pc)
  );

  always #5 clock = ~clock;

  assign rom_ack = auto_ack | man_ack;

  always @(posedge clock) begin
    #1;
    rom_data = {1'b0, rom_addr} + 16'h1000;
    if (rom_req) begin
      if (wait_cnt >= ((rom_addr == slow_addr) ? 3 : 0)) begin
        auto_ack = 1'b1;
        wait_cnt = 0;
      end else begin
        auto_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      auto_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset && inst_valid && inst_ready && !jump) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_inst: got pc 0x%0h data 0x%0h, expected no entry", inst_pc, inst_data);
      end else begin
        e = exp_q.pop_front();
        check("inst_pc", 32'(inst_pc), 32'(e.pc));
        check("inst_data", 32'(inst_data), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic expect_inst(input logic [14:0] pc, input logic [15:0] data);
    exp_q.push_back('{pc: pc, data: data});
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    inst_ready = 1'b0;
    jump       = 1'b0;
    jump_addr  = 15'd0;
    man_ack    = 1'b0;
    slow_addr  = 15'h5555;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_req(input logic [14:0] addr, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      sample();
      if (rom_req && rom_addr == addr) found = 1'b1;
    end
    checks++;
    if (!found) begin
      fails++;
      $display("FAIL %s: no rom_req for addr 0x%0h within 64 cycles, required one", name, addr);
    end
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      tick();
      if (exp_q.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL %s: %0d expected entries never delivered, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state, first request latency, streaming at one per two cycles.
    do_reset();
    inst_ready = 1'b1;
    expect_inst(15'h0000, 16'h1000);
    expect_inst(15'h0001, 16'h1001);
    expect_inst(15'h0002, 16'h1002);
    sample();
    check("reset_rom_req", 32'(rom_req), 32'h0);
    check("reset_rom_addr", 32'(rom_addr), 32'h0);
    check("reset_inst_valid", 32'(inst_valid), 32'h0);
    check("reset_inst_data", 32'(inst_data), 32'h0);
    check("reset_inst_pc", 32'(inst_pc), 32'h0);
    sample();
    check("first_rom_req", 32'(rom_req), 32'h1);
    check("first_rom_addr", 32'(rom_addr), 32'h0);
    check("first_inst_valid", 32'(inst_valid), 32'h0);
    for (int i = 0; i < 5; i++) begin
      sample();
      check("stream_valid", 32'(inst_valid), 32'((i % 2) == 0));
    end
    drain("stream_drain");

    // Back-pressure: buffer fills to two, fetch stalls, then drains in order.
    do_reset();
    repeat (6) tick();
    sample();
    check("full_inst_valid", 32'(inst_valid), 32'h1);
    check("full_inst_pc", 32'(inst_pc), 32'h0);
    check("full_inst_data", 32'(inst_data), 32'h1000);
    check("full_rom_req", 32'(rom_req), 32'h0);
    expect_inst(15'h0000, 16'h1000);
    expect_inst(15'h0001, 16'h1001);
    expect_inst(15'h0002, 16'h1002);
    tick();
    inst_ready = 1'b1;
    sample();
    sample();
    check("resume_rom_req", 32'(rom_req), 32'h1);
    check("resume_rom_addr", 32'(rom_addr), 32'h2);
    drain("backpressure_drain");

    // Jump while the request for addr 5 waits on a slow ROM.
    do_reset();
    inst_ready = 1'b1;
    slow_addr  = 15'd5;
    expect_inst(15'h0000, 16'h1000);
    expect_inst(15'h0001, 16'h1001);
    expect_inst(15'h0002, 16'h1002);
    expect_inst(15'h0003, 16'h1003);
    expect_inst(15'h0004, 16'h1004);
    expect_inst(15'h0100, 16'h1100);
    wait_req(15'd5, "req_addr5");
    tick();
    jump      = 1'b1;
    jump_addr = 15'h0100;
    tick();
    jump = 1'b0;
    sample();
    check("drop_rom_req", 32'(rom_req), 32'h1);
    check("drop_rom_addr", 32'(rom_addr), 32'h5);
    sample();
    sample();
    check("after_drop_rom_req", 32'(rom_req), 32'h0);
    check("after_drop_valid", 32'(inst_valid), 32'h0);
    sample();
    check("redirect_rom_req", 32'(rom_req), 32'h1);
    check("redirect_rom_addr", 32'(rom_addr), 32'h0100);
    drain("redirect_drain");

    // Jump coincident with rom_ack and a pop.
    do_reset();
    expect_inst(15'h0200, 16'h1200);
    wait_req(15'd1, "req_addr1");
    check("pre_jump_valid", 32'(inst_valid), 32'h1);
    check("pre_jump_pc", 32'(inst_pc), 32'h0);
    #1;
    jump       = 1'b1;
    jump_addr  = 15'h0200;
    inst_ready = 1'b1;
    tick();
    jump = 1'b0;
    sample();
    check("flush_valid", 32'(inst_valid), 32'h0);
    check("flush_rom_req", 32'(rom_req), 32'h0);
    sample();
    check("jump_rom_req", 32'(rom_req), 32'h1);
    check("jump_rom_addr", 32'(rom_addr), 32'h0200);
    drain("coincident_drain");

    // A second jump while draining only retargets fetch_pc.
    do_reset();
    inst_ready = 1'b1;
    slow_addr  = 15'd0;
    expect_inst(15'h0340, 16'h1340);
    wait_req(15'd0, "req_addr0");
    tick();
    jump      = 1'b1;
    jump_addr = 15'h0300;
    tick();
    jump_addr = 15'h0340;
    sample();
    check("drop2_rom_req", 32'(rom_req), 32'h1);
    check("drop2_rom_addr", 32'(rom_addr), 32'h0);
    tick();
    jump = 1'b0;
    drain("double_jump_drain");

    // fetch_pc wraps at the top of the 15-bit space.
    do_reset();
    inst_ready = 1'b1;
    jump       = 1'b1;
    jump_addr  = 15'h7FFE;
    expect_inst(15'h7FFE, 16'h8FFE);
    expect_inst(15'h7FFF, 16'h8FFF);
    expect_inst(15'h0000, 16'h1000);
    tick();
    jump = 1'b0;
    drain("wrap_drain");

    // Reset mid-request with a buffered entry; a late ack must be ignored.
    do_reset();
    slow_addr = 15'd1;
    wait_req(15'd1, "req_addr1_slow");
    check("pre_reset_valid", 32'(inst_valid), 32'h1);
    #1;
    reset = 1'b1;
    tick();
    sample();
    check("midreset_rom_req", 32'(rom_req), 32'h0);
    check("midreset_rom_addr", 32'(rom_addr), 32'h0);
    check("midreset_inst_valid", 32'(inst_valid), 32'h0);
    check("midreset_inst_data", 32'(inst_data), 32'h0);
    check("midreset_inst_pc", 32'(inst_pc), 32'h0);
    tick();
    reset   = 1'b0;
    man_ack = 1'b1;
    tick();
    man_ack    = 1'b0;
    inst_ready = 1'b1;
    expect_inst(15'h0000, 16'h1000);
    sample();
    check("late_ack_no_entry", 32'(inst_valid), 32'h0);
    check("late_ack_rom_req", 32'(rom_req), 32'h1);
    check("late_ack_rom_addr", 32'(rom_addr), 32'h0);
    drain("late_ack_drain");

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
